imu_message_mc393: RTL and testbench
====================================

IMU_MESSAGE_MC393 -- requirements
Module: imu_message_mc393

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent trigger/message channels, 1..8.
REQ-002 Parameter MSG_WORDS, default 14: 32-bit words per channel message, 56 bytes, power of two not required.
REQ-003 Parameter DENOISE_W, default 8: width of the de-noise counter.
REQ-004 Ports: mclk, in, 1, sole clock, all logic on posedge; mrst, in, 1, reset, synchronous, active-high.
REQ-005 Ports: en, in, 1, module enable (0 = same clear as mrst, except buffer); mode, in, 2*NUM_CH, per-channel mode (2 bits each); denoise_len, in, DENOISE_W, de-noise length L.
REQ-006 Ports: we, in, 1, buffer write; wa, in, clog2(NUM_CH)+clog2(MSG_WORDS), write address {chn, word}; din, in, 32, write data.
REQ-007 Ports: trig, in, NUM_CH, asynchronous trigger inputs; ts, out, NUM_CH, one-cycle timestamp request per channel.
REQ-008 Ports: rdy, out, 1, message ready; rdy_chn, out, clog2(NUM_CH), channel being presented; rd_stb, in, 1, read strobe; rdata, out, 16, read data; overrun, out, NUM_CH, sticky per-channel overrun.

Function
REQ-009 Mode encoding: 0 = off (channel ignored), 1 = gated (rising edge -> ts, falling edge -> message pending), 2 = pulse (rising edge -> ts and pending in the same cycle, falling edge ignored), 3 = reserved, treated as off.
REQ-010 Each trig bit passes a 3-flop synchronizer; the filtered level flips after the (L+1)th consecutive edge on which the synchronized input differs from it; any agreeing sample reloads the counter to L.
REQ-011 Filtered edges are registered once; ts[ch] is high for exactly one cycle, two edges after the filtered flip.
REQ-012 Buffer: NUM_CH*MSG_WORDS x 32, written at posedge mclk when we; write never blocked; written at address wa only.
REQ-013 Arbiter: when rdy is low and any pending bit is set, next edge selects a channel round-robin, starting after the last served channel; it asserts rdy, loads rdy_chn, and clears raddr.
REQ-014 rdata = buffer[rdy_chn][raddr>>1], bits [31:16] when raddr[0]=0, else [15:0]; combinational from raddr.
REQ-015 rd_stb with rdy high increments raddr; rd_stb with rdy low is ignored.
REQ-016 rd_stb at raddr = 2*MSG_WORDS-1 clears that channel's pending and rdy at the next edge; no new selection in that same edge (min one idle cycle).
REQ-017 ts on a channel whose pending is set (selected or not) clears its pending and sets overrun[ch]; if selected, rdy drops and raddr clears at the same edge; ts wins over a simultaneous rd_stb.
REQ-018 Pending set/clear events on different channels in one cycle are all honoured.
REQ-019 Changing mode of a channel to off clears its pending at the next edge; a selected channel drops rdy.
REQ-020 overrun bits clear only on mrst or en low.

Reset
REQ-021 On mrst or !en (synchronous): ts=0, rdy=0, rdy_chn=0, overrun=0, raddr=0, pending=0, synchronizers and filtered levels=0, counters=L, round-robin pointer=0; buffer contents retained.
REQ-022 Reset mid-read aborts the message; nothing resumes after reset.

Structure
REQ-023 Mode encodings and the clog2 helper belong in the shared logger include; no per-module duplicates.
REQ-024 One sub-module imu_trig_denoise (synchronizer, counter, filtered level, rise/fall pulses), instantiated NUM_CH times.

Verification
REQ-025 L=3, mode0=1, trig[0] high sampled at edge 1 -> ts[0] high for exactly the cycle after edge 9; 3-cycle glitch -> no ts.
REQ-026 Gated ch0: write 14 words 0x00010002.., trig pulse -> ts, then rdy after fall; 28 rd_stb yield 0x0001,0x0002,...; rdy low after the 28th.
REQ-027 Pulse mode on ch1 and ch2 simultaneously -> ch1 served first, idle cycle, then ch2; rdy_chn matches.
REQ-028 New trig on ch0 at raddr=5 with rd_stb same cycle -> rdy drops, raddr=0, overrun[0]=1 until en low.
REQ-029 mrst asserted at raddr=10 -> all outputs 0 next edge; buffer reread after new trigger returns original data.

Source files
------------

// File: rtl/imu_message_mc393_pkg.sv
// rtl/imu_message_mc393_pkg.sv - shared trigger modes and width helper for the IMU message logger
package imu_message_mc393_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_GATED = 2'd1,
        MODE_PULSE = 2'd2,
        MODE_RSVD  = 2'd3
    } trig_mode_e;

    // Never returns less than 1 so single-channel builds keep a legal select width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/imu_trig_denoise.sv
// rtl/imu_trig_denoise.sv - trigger synchronizer, de-noise filter and registered edge pulses
module imu_trig_denoise #(
    parameter int DENOISE_W = 8
) (
    input  logic                 mclk,
    input  logic                 clr,
    input  logic                 trig,
    input  logic [DENOISE_W-1:0] denoise_len,
    output logic                 rise,
    output logic                 fall
);

    logic [2:0]           sync;
    logic                 filt;
    logic                 filt_d;
    logic [DENOISE_W-1:0] cnt;

    always_ff @(posedge mclk) begin
        if (clr) begin
            sync   <= 3'b000;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            cnt    <= denoise_len;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync <= {sync[1:0], trig};
            // Level flips only after len+1 consecutive disagreeing samples.
            if (sync[2] == filt) begin
                cnt <= denoise_len;
            end else if (cnt == '0) begin
                filt <= sync[2];
                cnt  <= denoise_len;
            end else begin
                cnt <= cnt - 1'b1;
            end
            filt_d <= filt;
            rise   <= filt & ~filt_d;
            fall   <= ~filt & filt_d;
        end
    end

endmodule

// File: rtl/imu_message_mc393.sv
// rtl/imu_message_mc393.sv - per-channel trigger timestamps, message buffer and round-robin 16-bit readout
module imu_message_mc393
    import imu_message_mc393_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MSG_WORDS = 14,
    parameter int DENOISE_W = 8,
    localparam int CW = clog2(NUM_CH),
    localparam int WW = clog2(MSG_WORDS),
    localparam int RW = clog2(2 * MSG_WORDS),
    localparam int AW = clog2(NUM_CH * MSG_WORDS)
) (
    input  logic                 mclk,
    input  logic                 mrst,
    input  logic                 en,
    input  logic [2*NUM_CH-1:0]  mode,
    input  logic [DENOISE_W-1:0] denoise_len,
    input  logic                 we,
    input  logic [CW+WW-1:0]     wa,
    input  logic [31:0]          din,
    input  logic [NUM_CH-1:0]    trig,
    output logic [NUM_CH-1:0]    ts,
    output logic                 rdy,
    output logic [CW-1:0]        rdy_chn,
    input  logic                 rd_stb,
    output logic [15:0]          rdata,
    output logic [NUM_CH-1:0]    overrun
);

    logic              clr;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] ts_next;
    logic [NUM_CH-1:0] pend_set;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] pend_next;
    logic [NUM_CH-1:0] ovr_evt;
    logic [NUM_CH-1:0] kill;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] done_mask;
    logic              done;
    logic              sel_found;
    logic [CW-1:0]     sel_chn;
    logic [CW-1:0]     last_chn;
    logic [RW-1:0]     raddr;

    logic [31:0]       msg_buf [NUM_CH*MSG_WORDS];
    logic [CW-1:0]     wr_chn;
    logic [WW-1:0]     wr_word;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [31:0]       rd_word;

    assign clr = mrst | ~en;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_denoise
        imu_trig_denoise #(
            .DENOISE_W   (DENOISE_W)
        ) u_denoise (
            .mclk        (mclk),
            .clr         (clr),
            .trig        (trig[ch]),
            .denoise_len (denoise_len),
            .rise        (rise[ch]),
            .fall        (fall[ch])
        );
    end

    always_comb begin
        active   = '0;
        pend_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i]   = (mode[2*i +: 2] == MODE_GATED) || (mode[2*i +: 2] == MODE_PULSE);
            pend_set[i] = ((mode[2*i +: 2] == MODE_GATED) && fall[i]) ||
                          ((mode[2*i +: 2] == MODE_PULSE) && rise[i]);
        end
    end

    // A timestamp on an already pending channel means the host lost that message.
    assign ts_next  = rise & active;
    assign ovr_evt  = ts_next & pending;
    assign kill     = ovr_evt | ~active;
    assign eligible = pending & ~kill;

    assign done      = rdy & rd_stb & ~kill[rdy_chn] && (raddr == RW'(2 * MSG_WORDS - 1));
    assign done_mask = done ? (NUM_CH'(1) << rdy_chn) : '0;
    assign pend_next = ((pending & ~done_mask) | pend_set) & ~ovr_evt & active;

    always_comb begin
        sel_found = 1'b0;
        sel_chn   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!sel_found && eligible[(int'(last_chn) + i) % NUM_CH]) begin
                sel_found = 1'b1;
                sel_chn   = CW'((int'(last_chn) + i) % NUM_CH);
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (clr) begin
            ts       <= '0;
            pending  <= '0;
            overrun  <= '0;
            rdy      <= 1'b0;
            rdy_chn  <= '0;
            raddr    <= '0;
            last_chn <= '0;
        end else begin
            ts      <= ts_next;
            pending <= pend_next;
            overrun <= overrun | ovr_evt;
            if (rdy) begin
                if (kill[rdy_chn] || done) begin
                    rdy   <= 1'b0;
                    raddr <= '0;
                end else if (rd_stb) begin
                    raddr <= raddr + 1'b1;
                end
            end else if (sel_found) begin
                rdy      <= 1'b1;
                rdy_chn  <= sel_chn;
                raddr    <= '0;
                last_chn <= sel_chn;
            end
        end
    end

    // Buffer is never cleared by reset so the host may re-read after a restart.
    assign wr_chn  = wa[CW+WW-1:WW];
    assign wr_word = wa[WW-1:0];
    assign wr_idx  = AW'(wr_chn) * AW'(MSG_WORDS) + AW'(wr_word);

    always_ff @(posedge mclk) begin
        if (we && (int'(wr_chn) < NUM_CH) && (int'(wr_word) < MSG_WORDS)) begin
            msg_buf[wr_idx] <= din;
        end
    end

    assign rd_idx  = AW'(rdy_chn) * AW'(MSG_WORDS) + AW'(raddr >> 1);
    assign rd_word = msg_buf[rd_idx];
    assign rdata   = raddr[0] ? rd_word[15:0] : rd_word[31:16];

endmodule

// File: tb/tb_imu_message_mc393.sv
// tb/tb_imu_message_mc393.sv - self-checking bench for imu_message_mc393
module tb_imu_message_mc393;

    localparam int NUM_CH    = 4;
    localparam int MSG_WORDS = 14;
    localparam int NRD       = 2 * MSG_WORDS;

    logic        mclk = 1'b0;
    logic        mrst;
    logic        en;
    logic [7:0]  mode;
    logic [7:0]  denoise_len;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] din;
    logic [3:0]  trig;
    logic [3:0]  ts;
    logic        rdy;
    logic [1:0]  rdy_chn;
    logic        rd_stb;
    logic [15:0] rdata;
    logic [3:0]  overrun;

    int checks   = 0;
    int failures = 0;
    int rr_last  = 0;
    logic [31:0] mem_model [NUM_CH*MSG_WORDS];

    imu_message_mc393 #(
        .NUM_CH      (NUM_CH),
        .MSG_WORDS   (MSG_WORDS),
        .DENOISE_W   (8)
    ) dut (
        .mclk        (mclk),
        .mrst        (mrst),
        .en          (en),
        .mode        (mode),
        .denoise_len (denoise_len),
        .we          (we),
        .wa          (wa),
        .din         (din),
        .trig        (trig),
        .ts          (ts),
        .rdy         (rdy),
        .rdy_chn     (rdy_chn),
        .rd_stb      (rd_stb),
        .rdata       (rdata),
        .overrun     (overrun)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    function automatic logic [15:0] exp_half(int ch, int k);
        logic [31:0] w;
        w = mem_model[ch * MSG_WORDS + k / 2];
        return (k % 2 == 0) ? w[31:16] : w[15:0];
    endfunction

    task automatic reset_dut();
        mrst = 1'b1;
        tick();
        mrst = 1'b0;
        rr_last = 0;
    endtask

    task automatic write_word(int ch, int w, logic [31:0] d);
        we  = 1'b1;
        wa  = {2'(ch), 4'(w)};
        din = d;
        tick();
        we  = 1'b0;
        mem_model[ch * MSG_WORDS + w] = d;
    endtask

    task automatic trig_pulse(int ch, int len);
        trig[ch] = 1'b1;
        repeat (len) tick();
        trig[ch] = 1'b0;
    endtask

    task automatic wait_rdy(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 8'h00; denoise_len = 8'd3; we = 1'b0; wa = '0; din = '0;
        trig = '0; rd_stb = 1'b0; mrst = 1'b1;
        tick(); tick();
        mrst = 1'b0;
        checks++; if (ts !== 4'h0) begin failures++; $display("FAIL reset_ts got=%h exp=0", ts); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        checks++; if (rdy_chn !== 2'd0) begin failures++; $display("FAIL reset_rdy_chn got=%0d exp=0", rdy_chn); end
        checks++; if (overrun !== 4'h0) begin failures++; $display("FAIL reset_overrun got=%h exp=0", overrun); end
    endtask

    task automatic test_denoise();
        bit seen;
        denoise_len = 8'd3; mode = 8'h01; trig = '0;
        reset_dut();
        trig[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (ts[0] !== (e == 9)) begin
                failures++; $display("FAIL denoise_ts edge=%0d got=%b exp=%b", e, ts[0], (e == 9));
            end
        end
        trig = '0;
        reset_dut();
        tick();
        trig[0] = 1'b1;
        repeat (3) tick();
        trig[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | ts[0] | rdy;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_no_ts got=%b exp=0", seen); end
    endtask

    task automatic test_denoise_random();
        int l;
        int ch;
        for (int it = 0; it < 4; it++) begin
            l  = $urandom_range(0, 6);
            ch = $urandom_range(0, NUM_CH - 1);
            denoise_len = 8'(l);
            mode = 8'(2) << (2 * ch);
            trig = '0;
            reset_dut();
            trig[ch] = 1'b1;
            for (int e = 1; e <= l + 9; e++) begin
                tick();
                checks++;
                if (ts !== ((e == l + 6) ? 4'(1 << ch) : 4'h0)) begin
                    failures++; $display("FAIL rand_ts L=%0d ch=%0d edge=%0d got=%h", l, ch, e, ts);
                end
            end
            trig = '0;
            checks++;
            if (rdy !== 1'b1 || rdy_chn !== 2'(ch)) begin
                failures++; $display("FAIL rand_sel got=%b/%0d exp=1/%0d", rdy, rdy_chn, ch);
            end
        end
        denoise_len = 8'd3;
    endtask

    task automatic test_gated_read();
        bit seen_ts;
        mode = 8'h01; trig = '0;
        reset_dut();
        for (int w = 0; w < MSG_WORDS; w++) write_word(0, w, {16'(2 * w + 1), 16'(2 * w + 2)});
        trig_pulse(0, 6);
        seen_ts = 1'b0;
        for (int i = 0; i < 60 && rdy !== 1'b1; i++) begin
            seen_ts = seen_ts | ts[0];
            tick();
        end
        checks++; if (seen_ts !== 1'b1) begin failures++; $display("FAIL gated_ts got=%b exp=1", seen_ts); end
        checks++;
        if (rdy !== 1'b1 || rdy_chn !== 2'd0) begin
            failures++; $display("FAIL gated_rdy got=%b/%0d exp=1/0", rdy, rdy_chn);
        end
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdy !== 1'b1 || rdata !== exp_half(0, k)) begin
                failures++; $display("FAIL gated_data k=%0d got=%h exp=%h", k, rdata, exp_half(0, k));
            end
            rd_stb = 1'b1; tick(); rd_stb = 1'b0;
        end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL gated_done got=%b exp=0", rdy); end
    endtask

    task automatic test_pulse_rr();
        bit ok;
        mode = 8'h28; trig = '0;
        reset_dut();
        for (int c = 1; c <= 2; c++)
            for (int w = 0; w < MSG_WORDS; w++) write_word(c, w, $urandom);
        trig = 4'b0110;
        repeat (5) tick();
        trig = '0;
        wait_rdy(40, ok);
        checks++;
        if (!ok || rdy_chn !== 2'd1) begin failures++; $display("FAIL rr_first got=%b/%0d exp=1/1", ok, rdy_chn); end
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdata !== exp_half(1, k)) begin
                failures++; $display("FAIL rr_data1 k=%0d got=%h exp=%h", k, rdata, exp_half(1, k));
            end
            rd_stb = 1'b1; tick(); rd_stb = 1'b0;
        end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", rdy); end
        tick();
        checks++;
        if (rdy !== 1'b1 || rdy_chn !== 2'd2) begin failures++; $display("FAIL rr_second got=%b/%0d exp=1/2", rdy, rdy_chn); end
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdata !== exp_half(2, k)) begin
                failures++; $display("FAIL rr_data2 k=%0d got=%h exp=%h", k, rdata, exp_half(2, k));
            end
            rd_stb = 1'b1; tick(); rd_stb = 1'b0;
        end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rr_end got=%b exp=0", rdy); end
    endtask

    task automatic test_overrun();
        bit ok;
        mode = 8'h01; trig = '0;
        reset_dut();
        trig_pulse(0, 6);
        wait_rdy(60, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovr_first_rdy got=0 exp=1"); end
        trig[0] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            rd_stb = (e <= 5) || (e == 9);
            if (e == 9) begin
                checks++;
                if (rdy !== 1'b1 || rdata !== exp_half(0, 5)) begin
                    failures++; $display("FAIL ovr_raddr5 got=%b/%h exp=1/%h", rdy, rdata, exp_half(0, 5));
                end
            end
            tick();
        end
        rd_stb = 1'b0;
        checks++; if (ts[0] !== 1'b1) begin failures++; $display("FAIL ovr_ts got=%b exp=1", ts[0]); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL ovr_rdy_drop got=%b exp=0", rdy); end
        checks++; if (overrun !== 4'h1) begin failures++; $display("FAIL ovr_flag got=%h exp=1", overrun); end
        checks++;
        if (rdata !== exp_half(0, 0)) begin failures++; $display("FAIL ovr_raddr0 got=%h exp=%h", rdata, exp_half(0, 0)); end
        trig[0] = 1'b0;
        repeat (40) tick();
        checks++; if (overrun !== 4'h1) begin failures++; $display("FAIL ovr_sticky got=%h exp=1", overrun); end
        en = 1'b0; tick(); en = 1'b1;
        rr_last = 0;
        checks++;
        if (overrun !== 4'h0 || rdy !== 1'b0) begin failures++; $display("FAIL ovr_en_clear got=%h/%b exp=0/0", overrun, rdy); end
    endtask

    task automatic test_mode_off();
        bit ok;
        mode = 8'h08; trig = '0;
        reset_dut();
        trig_pulse(1, 5);
        wait_rdy(40, ok);
        checks++;
        if (!ok || rdy_chn !== 2'd1) begin failures++; $display("FAIL off_sel got=%b/%0d exp=1/1", ok, rdy_chn); end
        mode = 8'h00;
        tick();
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL off_drop got=%b exp=0", rdy); end
        mode = 8'h08;
        repeat (5) tick();
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL off_pending_cleared got=%b exp=0", rdy); end
    endtask

    task automatic test_reset_midread();
        bit ok;
        bit seen;
        mode = 8'h80; trig = '0;
        reset_dut();
        for (int w = 0; w < MSG_WORDS; w++) write_word(3, w, $urandom);
        trig_pulse(3, 5);
        wait_rdy(40, ok);
        checks++;
        if (!ok || rdy_chn !== 2'd3) begin failures++; $display("FAIL mid_sel got=%b/%0d exp=1/3", ok, rdy_chn); end
        for (int k = 0; k < 10; k++) begin
            rd_stb = 1'b1; tick(); rd_stb = 1'b0;
        end
        checks++;
        if (rdata !== exp_half(3, 10)) begin failures++; $display("FAIL mid_raddr10 got=%h exp=%h", rdata, exp_half(3, 10)); end
        mrst = 1'b1; tick(); mrst = 1'b0;
        rr_last = 0;
        checks++;
        if (rdy !== 1'b0 || ts !== 4'h0 || overrun !== 4'h0 || rdy_chn !== 2'd0) begin
            failures++; $display("FAIL mid_reset got=%b/%h/%h/%0d exp=0/0/0/0", rdy, ts, overrun, rdy_chn);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); seen = seen | rdy; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_resume got=%b exp=0", seen); end
        trig_pulse(3, 5);
        wait_rdy(40, ok);
        checks++;
        if (!ok || rdy_chn !== 2'd3) begin failures++; $display("FAIL mid_resel got=%b/%0d exp=1/3", ok, rdy_chn); end
        for (int k = 0; k < NRD; k++) begin
            checks++;
            if (rdata !== exp_half(3, k)) begin
                failures++; $display("FAIL mid_reread k=%0d got=%h exp=%h", k, rdata, exp_half(3, k));
            end
            rd_stb = 1'b1; tick(); rd_stb = 1'b0;
        end
    endtask

    task automatic test_random_msgs();
        bit ok;
        int mask;
        int exp_ch;
        trig = '0;
        reset_dut();
        for (int it = 0; it < 5; it++) begin
            mask = $urandom_range(1, 15);
            mode = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask[c]) begin
                    mode = mode | (8'(2) << (2 * c));
                    for (int w = 0; w < MSG_WORDS; w++) write_word(c, w, $urandom);
                end
            end
            trig = 4'(mask);
            repeat (5) tick();
            trig = '0;
            while (mask != 0) begin
                exp_ch = -1;
                for (int i = 1; i <= NUM_CH && exp_ch < 0; i++)
                    if (mask[(rr_last + i) % NUM_CH]) exp_ch = (rr_last + i) % NUM_CH;
                wait_rdy(60, ok);
                checks++;
                if (!ok || rdy_chn !== 2'(exp_ch)) begin
                    failures++; $display("FAIL rnd_order it=%0d got=%b/%0d exp=1/%0d", it, ok, rdy_chn, exp_ch);
                end
                for (int k = 0; k < NRD; k++) begin
                    checks++;
                    if (rdata !== exp_half(exp_ch, k)) begin
                        failures++; $display("FAIL rnd_data ch=%0d k=%0d got=%h exp=%h", exp_ch, k, rdata, exp_half(exp_ch, k));
                    end
                    rd_stb = 1'b1; tick(); rd_stb = 1'b0;
                end
                mask[exp_ch] = 1'b0;
                rr_last = exp_ch;
            end
            checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rnd_drained got=%b exp=0", rdy); end
        end
    endtask

    initial begin
        test_reset();
        test_denoise();
        test_denoise_random();
        test_gated_read();
        test_pulse_rr();
        test_overrun();
        test_mode_off();
        test_reset_midread();
        test_random_msgs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
